// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader
//
// Word-wide loader for the fabric configuration chain. Accepts DATA_W-bit
// words over a valid/ready handshake and shifts CHAIN_LEN bits, MSB of each
// word first, into ccff_head using a slow prog_clk. Each bit occupies
// CLK_DIV cycles with prog_clk low followed by CLK_DIV cycles with prog_clk high.
// The bit leaving the chain on ccff_tail is folded into a CRC-8 signature
// (poly 0x07) just before each prog_clk rise. The fabric user logic is held in
// reset until a pass completes.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   start       pulse; begins a pass from IDLE or DONE, ignored otherwise
//   cfg_data    configuration word, MSB shifted first
//   cfg_valid   cfg_data valid
//   cfg_ready   loader accepts cfg_data this cycle
//   prog_clk    configuration clock to fabric (registered)
//   ccff_head   serial configuration data to fabric (registered)
//   ccff_tail   serial data returning from the end of the chain
//   fabric_rst  active-high reset to fabric user logic
//   busy        programming pass in progress
//   done        pass complete, held until the next start
//   sig         CRC-8 signature of ccff_tail bits from the last pass
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, waiting for start
// FETCH    | cfg_ready high, waiting for the next word
// SHIFT_LO | prog_clk low, ccff_head driven, tail sampled on last cycle
// SHIFT_HI | prog_clk high, ccff_head stable, bit counted on exit
// DONE     | pass complete, fabric released, sig frozen

module fpga_cfg_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              prog_clk,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              fabric_rst,
    output logic              busy,
    output logic              done,
    output logic [7:0]        sig
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        sig_q;
    logic              prog_clk_q;
    logic              head_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              frst_q;

    logic              fb;
    logic [7:0]        sig_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  idx_d;

    always_comb begin
        fb    = sig_q[7] ^ ccff_tail;
        sig_d = {sig_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q - IDX_W'(1);
    end

    // prog_clk and every status output come straight from flops, so the
    // asynchronous reset forces prog_clk low without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            sig_q      <= 8'h00;
            prog_clk_q <= 1'b0;
            head_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frst_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sig_q      <= 8'h00;
                        cnt_q      <= '0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        frst_q     <= 1'b1;
                        ready_q    <= 1'b1;
                        prog_clk_q <= 1'b0;
                        state_q    <= FETCH;
                    end
                end

                FETCH: begin
                    if (cfg_valid && ready_q) begin
                        word_q  <= cfg_data;
                        idx_q   <= IDX_TOP;
                        head_q  <= cfg_data[DATA_W-1];
                        div_q   <= DIV_TOP;
                        ready_q <= 1'b0;
                        state_q <= SHIFT_LO;
                    end
                end

                SHIFT_LO: begin
                    // tail is sampled on the last low cycle, i.e. just before
                    // the fabric shifts on the coming prog_clk rise
                    if (div_q == '0) begin
                        sig_q      <= sig_d;
                        prog_clk_q <= 1'b1;
                        div_q      <= DIV_TOP;
                        state_q    <= SHIFT_HI;
                    end else begin
                        div_q <= div_q - DIV_W'(1);
                    end
                end

                SHIFT_HI: begin
                    if (div_q == '0) begin
                        prog_clk_q <= 1'b0;
                        cnt_q      <= cnt_d;
                        // chain length wins over word position, so the unused
                        // tail of a final partial word is simply dropped
                        if (cnt_d == CNT_LAST) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            frst_q  <= 1'b0;
                            state_q <= DONE;
                        end else if (idx_q == '0) begin
                            ready_q <= 1'b1;
                            state_q <= FETCH;
                        end else begin
                            idx_q   <= idx_d;
                            head_q  <= word_q[idx_d];
                            div_q   <= DIV_TOP;
                            state_q <= SHIFT_LO;
                        end
                    end else begin
                        div_q <= div_q - DIV_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready  = ready_q;
    assign prog_clk   = prog_clk_q;
    assign ccff_head  = head_q;
    assign fabric_rst = frst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sig        = sig_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader. Three instances share clock and reset:
//   u16: CHAIN_LEN=16, DATA_W=8, CLK_DIV=2, fed by a 16-bit chain model
//   u12: CHAIN_LEN=12, partial final word, stall in FETCH
//   u4 : CHAIN_LEN=4, tail driven 1,0,0,0 for the signature trace

module tb_fpga_cfg_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // u16 signals
    logic       start16, valid16, ready16, pclk16, head16, tail16, frst16, busy16, done16;
    logic [7:0] data16, sig16;
    // u12 signals
    logic       start12, valid12, ready12, pclk12, head12, tail12, frst12, busy12, done12;
    logic [7:0] data12, sig12;
    // u4 signals
    logic       start4, valid4, ready4, pclk4, head4, tail4, frst4, busy4, done4;
    logic [7:0] data4, sig4;

    int acc16 = 0, acc12 = 0, acc4 = 0;
    int edges16 = 0, edges12 = 0, edges4 = 0;
    int cyc = 0;
    int rise12 [0:15];
    logic [63:0] hist16 = '0, hist12 = '0;
    logic [31:0] trace4 = '0;
    logic [15:0] chain16 = '0;
    logic pp16 = 1'b0, pp12 = 1'b0, pp4 = 1'b0;
    logic rst_early16 = 1'b0;
    int base16 = 0;

    fpga_cfg_loader #(.CHAIN_LEN(16), .DATA_W(8), .CLK_DIV(2)) u16 (
        .clk(clk), .reset(reset), .start(start16), .cfg_data(data16),
        .cfg_valid(valid16), .cfg_ready(ready16), .prog_clk(pclk16),
        .ccff_head(head16), .ccff_tail(tail16), .fabric_rst(frst16),
        .busy(busy16), .done(done16), .sig(sig16));

    fpga_cfg_loader #(.CHAIN_LEN(12), .DATA_W(8), .CLK_DIV(2)) u12 (
        .clk(clk), .reset(reset), .start(start12), .cfg_data(data12),
        .cfg_valid(valid12), .cfg_ready(ready12), .prog_clk(pclk12),
        .ccff_head(head12), .ccff_tail(tail12), .fabric_rst(frst12),
        .busy(busy12), .done(done12), .sig(sig12));

    fpga_cfg_loader #(.CHAIN_LEN(4), .DATA_W(8), .CLK_DIV(2)) u4 (
        .clk(clk), .reset(reset), .start(start4), .cfg_data(data4),
        .cfg_valid(valid4), .cfg_ready(ready4), .prog_clk(pclk4),
        .ccff_head(head4), .ccff_tail(tail4), .fabric_rst(frst4),
        .busy(busy4), .done(done4), .sig(sig4));

    // word sources advance on each accepted handshake
    assign data16 = acc16[0] ? 8'h3C : 8'hA5;
    assign data12 = acc12[0] ? 8'h9F : 8'hFF;
    assign data4  = 8'hB0;
    assign tail16 = chain16[15];
    assign tail12 = 1'b0;
    assign tail4  = (edges4 == 0);

    always @(posedge clk) begin
        if (ready16 && valid16) acc16 <= acc16 + 1;
        if (ready12 && valid12) acc12 <= acc12 + 1;
        if (ready4 && valid4) acc4 <= acc4 + 1;
    end

    // fabric chain model for u16
    always @(posedge pclk16) chain16 <= {chain16[14:0], head16};

    // prog_clk rise monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        pp16 <= pclk16;
        pp12 <= pclk12;
        pp4  <= pclk4;
        if (pclk16 && !pp16) begin
            edges16 <= edges16 + 1;
            hist16  <= {hist16[62:0], head16};
        end
        if (pclk12 && !pp12) begin
            if (edges12 < 16) rise12[edges12] <= cyc;
            edges12 <= edges12 + 1;
            hist12  <= {hist12[62:0], head12};
        end
        if (pclk4 && !pp4) begin
            edges4 <= edges4 + 1;
            trace4 <= {trace4[23:0], sig4};
        end
        if (busy16 && !frst16) rst_early16 <= 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond(input int which);
        case (which)
            0: return done16;
            1: return done12;
            2: return done4;
            3: return pclk16;
            4: return (edges16 - base16) >= 6;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string tag, output int cycles);
        int n = 0;
        while (!cond(which) && n < budget) begin
            step(1);
            n++;
        end
        cycles = n;
        check(tag, {63'd0, cond(which)}, 64'd1);
    endtask

    initial begin
        int lat;
        int dummy;
        logic stall_ok;

        reset = 1'b1;
        start16 = 1'b0; start12 = 1'b0; start4 = 1'b0;
        valid16 = 1'b0; valid12 = 1'b0; valid4 = 1'b0;
        step(3);
        check("reset_values", {pclk16, head16, ready16, busy16, done16, frst16, sig16},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
        reset = 1'b0;
        step(2);
        check("idle_after_reset", {busy16, done16, frst16, ready16}, 4'b0010);

        // ---- u16 pass 1: chain model empty, tail all zero ----
        valid16 = 1'b1;
        base16 = edges16;
        start16 = 1'b1;
        step(1);
        start16 = 1'b0;
        check("p1_start_state", {busy16, frst16, ready16, done16}, 4'b1110);
        wait_for(0, 300, "p1_done_timeout", lat);
        check("p1_done_latency_ge64", {63'd0, (lat + 1) >= 64}, 64'd1);
        check("p1_edges", edges16 - base16, 16);
        check("p1_head_bits", hist16[15:0], 16'hA53C);
        check("p1_words", acc16, 2);
        check("p1_frst_with_done", {done16, frst16, busy16, pclk16}, 4'b1000);
        check("p1_frst_not_early", {63'd0, rst_early16}, 64'd0);
        check("p1_sig_zero_tail", sig16, 8'h00);
        step(4);
        check("p1_no_extra_word", {acc16, ready16}, {32'd2, 1'b0});

        // ---- u16 pass 2: start in DONE, chain returns pass-1 bits ----
        base16 = edges16;
        start16 = 1'b1;
        step(1);
        start16 = 1'b0;
        check("p2_start_in_done", {done16, frst16, busy16}, 3'b011);
        wait_for(4, 200, "p2_mid_timeout", dummy);
        start16 = 1'b1;
        step(1);
        start16 = 1'b0;
        check("p2_start_ignored_busy", {busy16, done16}, 2'b10);
        wait_for(0, 300, "p2_done_timeout", dummy);
        check("p2_edges", edges16 - base16, 16);
        check("p2_head_bits", hist16[15:0], 16'hA53C);
        // CRC-8/0x07 over 1010010100111100 from 0x00
        check("p2_sig", sig16, 8'hED);
        check("p2_words", acc16, 4);

        // ---- u12: stall in FETCH, then partial final word ----
        start12 = 1'b1;
        step(1);
        start12 = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(pclk12 == 1'b0 && busy12 == 1'b1 && ready12 == 1'b1)) stall_ok = 1'b0;
            step(1);
        end
        check("stall_hold", {63'd0, stall_ok}, 64'd1);
        check("stall_no_edges", edges12, 0);
        valid12 = 1'b1;
        wait_for(1, 300, "u12_done_timeout", dummy);
        check("u12_edges", edges12, 12);
        check("u12_head_bits", hist12[11:0], 12'hFF9);
        check("u12_last4", hist12[3:0], 4'b1001);
        for (int k = 1; k < 12; k++) begin
            check($sformatf("u12_gap_%0d", k), rise12[k] - rise12[k-1], (k == 8) ? 5 : 4);
        end
        step(5);
        check("u12_no_third_word", {acc12, ready12}, {32'd2, 1'b0});

        // ---- u4: signature trace with tail 1,0,0,0 ----
        valid4 = 1'b1;
        start4 = 1'b1;
        step(1);
        start4 = 1'b0;
        wait_for(2, 200, "u4_done_timeout", dummy);
        check("u4_edges", edges4, 4);
        check("u4_sig_trace", trace4, 32'h070E1C38);
        check("u4_sig_final", sig4, 8'h38);
        check("u4_words", acc4, 1);

        // ---- reset in the middle of SHIFT_HI on u16 ----
        start16 = 1'b1;
        step(1);
        start16 = 1'b0;
        wait_for(3, 50, "p3_hi_timeout", dummy);
        check("p3_sig_before_reset", sig16, 8'h07);
        reset = 1'b1;
        #1;
        check("reset_mid_pass", {pclk16, busy16, done16, frst16, sig16, ready16},
              {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
        step(2);
        reset = 1'b0;
        step(3);
        check("after_reset_idle", {pclk16, busy16, done16, frst16, ready16}, 5'b00010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
